// File: rtl/alu_64.sv
// alu_64 -- 64-bit integer ALU for the Y86-64 execute stage.
//
// Computes add / sub / and / xor of two signed 64-bit operands and reports
// signed overflow, zero and sign indicators alongside the result.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   valid_in   in   1   opcode/operands valid this cycle
//   opcode     in   2   00 add, 01 sub, 10 and, 11 xor
//   a, b       in   64  signed operands
//   valid_out  out  1   res and flags valid
//   res        out  64  result
//   overflow   out  1   signed overflow (add/sub only)
//   zero       out  1   res == 0
//   sign       out  1   res[63]
//
// Build option: define ALU_64_COMB_OUT_EN for purely combinational outputs
// (zero latency, valid_out = valid_in, clk/rst ignored). Default build
// registers the outputs with one cycle of latency.

module alu_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [1:0]  opcode,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        valid_out,
  output logic [63:0] res,
  output logic        overflow,
  output logic        zero,
  output logic        sign
);

  // Subtract reuses the adder: a + ~b + 1.
  logic        w_sub;
  logic [63:0] w_b_op;
  logic [63:0] w_sum;
  logic [63:0] w_res;
  logic        w_ovf;

  assign w_sub  = (opcode == 2'b01);
  assign w_b_op = w_sub ? ~b : b;
  assign w_sum  = a + w_b_op + {63'd0, w_sub};

  always_comb begin
    w_res = w_sum;
    case (opcode)
      2'b10:   w_res = a & b;
      2'b11:   w_res = a ^ b;
      default: w_res = w_sum;
    endcase
  end

  // With the effective operand (~b for sub), both add and sub overflow
  // reduce to: operands agree in sign and the sum's sign differs.
  assign w_ovf = ~opcode[1] & (a[63] == w_b_op[63]) & (w_sum[63] != a[63]);

`ifdef ALU_64_COMB_OUT_EN

  logic w_unused;
  assign w_unused = &{1'b0, clk, rst};

  assign valid_out = valid_in;
  assign res       = w_res;
  assign overflow  = w_ovf;
  assign zero      = (w_res == 64'd0);
  assign sign      = w_res[63];

`else

  logic [63:0] r_res;
  logic        r_ovf;
  logic        r_zero;
  logic        r_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res  <= 64'd0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= valid_in;
      // Result and flags hold when no operation is presented.
      if (valid_in) begin
        r_res  <= w_res;
        r_ovf  <= w_ovf;
        r_zero <= (w_res == 64'd0);
      end
    end
  end

  assign valid_out = r_vld;
  assign res       = r_res;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign sign      = r_res[63];

`endif

endmodule

// File: tb/tb_alu_64.sv
// Directed-vector bench for alu_64 (registered build by default; also
// covers the combinational build when ALU_64_COMB_OUT_EN is defined).

module tb_alu_64;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [1:0]  opcode;
  logic [63:0] a, b;
  logic        valid_out;
  logic [63:0] res;
  logic        overflow, zero, sign;

  int n_chk  = 0;
  int n_fail = 0;

  alu_64 dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode),
    .a(a), .b(b), .valid_out(valid_out), .res(res),
    .overflow(overflow), .zero(zero), .sign(sign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic [63:0] e_res,
                         input logic e_ov, input logic e_z, input logic e_s,
                         input logic e_vo);
    chk({tag, ".res"}, res, e_res);
    chk({tag, ".ovf"}, {63'd0, overflow}, {63'd0, e_ov});
    chk({tag, ".zero"}, {63'd0, zero}, {63'd0, e_z});
    chk({tag, ".sign"}, {63'd0, sign}, {63'd0, e_s});
    chk({tag, ".vld"}, {63'd0, valid_out}, {63'd0, e_vo});
  endtask

  // Apply inputs away from the active edge, then move to the sample point.
  task automatic drive(input logic r, input logic v, input logic [1:0] op,
                       input logic [63:0] ia, input logic [63:0] ib);
    @(negedge clk);
    rst = r; valid_in = v; opcode = op; a = ia; b = ib;
`ifdef ALU_64_COMB_OUT_EN
    #1;
`else
    @(posedge clk);
    #1;
`endif
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b1; opcode = 2'b00; a = 64'd5; b = 64'd7;

`ifndef ALU_64_COMB_OUT_EN
    repeat (2) @(posedge clk);
    #1;
    exp_out("reset", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    drive(0, 1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    exp_out("add_ovf", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(0, 1, 2'b00, 64'd10, -64'sd3);
    exp_out("add_neg", 64'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 1, 2'b01, 64'h8000_0000_0000_0000, 64'd1);
    exp_out("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(0, 1, 2'b01, 64'd9, 64'd9);
    exp_out("sub_zero", 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(0, 1, 2'b10, 64'hF0F0, 64'hFF00);
    exp_out("and", 64'hF000, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 1, 2'b11, 64'hF0F0, 64'hFF00);
    exp_out("xor", 64'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 1, 2'b10, 64'hF000_0000_0000_F0F0, 64'hFF00_0000_0000_FF00);
    exp_out("and_neg", 64'hF000_0000_0000_F000, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(0, 1, 2'b11, 64'hF000_0000_0000_F0F0, 64'hFF00_0000_0000_FF00);
    exp_out("xor_neg", 64'h0F00_0000_0000_0FF0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 1, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_out("sub_ovf_pos", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Back-to-back with opcode changes.
    drive(0, 1, 2'b00, 64'd1, 64'd2);
    exp_out("b2b_add", 64'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 1, 2'b01, 64'd1, 64'd2);
    exp_out("b2b_sub", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(0, 1, 2'b11, 64'd3, 64'd3);
    exp_out("b2b_xor", 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);

`ifdef ALU_64_COMB_OUT_EN
    drive(0, 0, 2'b00, 64'd4, 64'd5);
    exp_out("comb_novld", 64'd9, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    // Idle cycles: outputs hold the last result.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
      exp_out("hold", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Mid-stream reset discards the in-flight operation.
    drive(0, 1, 2'b00, 64'd4, 64'd5);
    exp_out("pre_rst", 64'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1, 1, 2'b00, 64'd1, 64'd1);
    exp_out("mid_rst", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 2'b00, 64'd7, 64'd7);
    exp_out("post_rst_idle", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1, 2'b00, 64'd2, 64'd2);
    exp_out("post_rst_first", 64'd4, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_64.md
# alu_64

64-bit integer ALU for the Y86-64 sequential processor's execute stage. It computes add, subtract, AND or XOR of two signed 64-bit operands and produces the result plus overflow and zero condition indicators. The execute stage derives the ZF/SF/OF condition codes for cmovXX/jXX from these outputs. By default the outputs are registered, giving one cycle of latency.

## Interface
- No parameters; the datapath width is fixed at 64 bits.
- Clocking and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  operands and opcode are valid this cycle.
- opcode  input  2  operation select: 00 add, 01 sub, 10 and, 11 xor.
- a  input  64  operand A, signed two's complement.
- b  input  64  operand B, signed two's complement.
- valid_out  output  1  res and flags are valid.
- res  output  64  signed result.
- overflow  output  1  signed overflow (add/sub only).
- zero  output  1  active-high; 1 when res == 0.
- sign  output  1  res[63].

## Operation
- opcode 00: res = a + b, modulo 2^64.
- opcode 01: res = a − b, modulo 2^64. Implement as a + ~b + 1 through the same 64-bit adder.
- opcode 10: res = a & b, bitwise.
- opcode 11: res = a ^ b, bitwise.
- overflow for add: a[63] == b[63] and res[63] != a[63].
- overflow for sub: a[63] != b[63] and res[63] != a[63].
- overflow for and/xor: always 0.
- zero = (res == 64'd0) for every opcode.
- sign = res[63] for every opcode.
- The ALU holds no architectural state. The condition codes (including the "set only on OPq" rule) are kept by the execute stage, not by this block.

## Timing
- Registered mode (default):
  - When valid_in = 1 at a rising edge, res, overflow, zero and sign update from that cycle's inputs, and valid_out = 1 on the next cycle.
  - When valid_in = 0, res and all flags hold their previous values, and valid_out = 0 the next cycle.
- Latency is exactly 1 cycle. Full throughput: a new operation is accepted every cycle, with no stall or backpressure.
- Reset: when rst = 1 at an edge, res = 0, overflow = 0, zero = 1, sign = 0, valid_out = 0. Reset takes priority over a simultaneous valid_in.
- Reset asserted mid-stream discards the in-flight result. The first valid_in after rst deasserts produces valid_out one cycle later.
- Changing the opcode between back-to-back valid cycles is legal; each result reflects only its own cycle's inputs.

## Configuration
- ALU_64_COMB_OUT_EN defined:
  - res, overflow, zero and sign are purely combinational from opcode, a and b, with zero latency.
  - valid_out = valid_in combinationally.
  - clk and rst remain ports but have no effect.
  - This is the mode the single-cycle execute stage uses.
- ALU_64_COMB_OUT_EN undefined: registered behaviour as described in Timing.
- Arithmetic and flag equations are identical in both modes.

## Test plan
- Reset: assert rst for 2 cycles with valid_in = 1, a = 5, b = 7 -> res = 0, zero = 1, overflow = 0, sign = 0, valid_out = 0.
- Add: a = 0x7FFF_FFFF_FFFF_FFFF, b = 1, opcode 00 -> next cycle res = 0x8000_0000_0000_0000, overflow = 1, sign = 1, zero = 0. Also a = 10, b = −3 -> res = 7, overflow = 0.
- Sub: a = 0x8000_0000_0000_0000, b = 1, opcode 01 -> res = 0x7FFF_FFFF_FFFF_FFFF, overflow = 1, sign = 0. Also a = 9, b = 9 -> res = 0, zero = 1.
- Logic: a = 0xF0F0, b = 0xFF00 -> opcode 10 gives 0xF000; opcode 11 gives 0x0FF0; overflow = 0 in both cases even when both operands are negative.
- Hold and pipelining:
  - Back-to-back add(1,2), sub(1,2), xor(3,3) -> results 3, −1 (sign = 1), 0 (zero = 1) on consecutive cycles.
  - Then valid_in = 0 with random operands -> outputs hold 0/zero = 1 and valid_out = 0.
- Combinational build (ALU_64_COMB_OUT_EN): repeat the add-overflow vector -> outputs are correct within the same cycle and valid_out tracks valid_in.
